data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and a word-wide backing memory. On a hit it serves loads combinationally and commits stores at the clock edge. On a miss it raises `stall`, optionally writes back the dirty victim line, refills the line one word per memory beat, and then releases the pipeline, which replays the same access as a hit.

---
 rtl/data_cache_if.sv | 14 +
 rtl/data_cache.sv | 181 ++++++++++++++++++
 tb/tb_data_cache.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Backing-memory beat bus for data_cache: the cache is master, the memory is slave.
interface data_cache_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ready);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_rdata, mem_ready);
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache, 4-word lines, word-wide refill.
// Optional hit/miss counters when DCACHE_STATS_EN is defined.
module data_cache #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   input  logic        memWrite,
   input  logic        memRead,
   output logic [31:0] readData,
   data_cache_if.master mem,
`ifdef DCACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   output logic        stall
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 28 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              beat_q, beat_d, beat_n;
   logic [31:0]             miss_addr_q;
   logic                    req_q, req_d, we_q, we_d;
   logic [31:0]             addr_q, addr_d, wdata_q, wdata_d;

   logic [LINES-1:0]        valid_q, dirty_q;
   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [31:0]             data_q [LINES][4];

   logic [INDEX_BITS-1:0]   idx, m_idx;
   logic [TAG_W-1:0]        tag, m_tag;
   logic [1:0]              wsel;
   logic                    req, hit, idle, hit_store;
   logic                    start_miss, wb_done, rf_wr, rf_done;
   logic                    unused_bits;

   assign idx   = address[INDEX_BITS+3:4];
   assign tag   = address[31:INDEX_BITS+4];
   assign wsel  = address[3:2];
   assign m_idx = miss_addr_q[INDEX_BITS+3:4];
   assign m_tag = miss_addr_q[31:INDEX_BITS+4];
   assign unused_bits = ^{address[1:0], miss_addr_q[3:0]};

   assign req       = memRead | memWrite;
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign idle      = (state_q == IDLE);
   assign hit_store = reset && idle && memWrite && hit;
   assign beat_n    = beat_q + 2'd1;

   // Reset forces stall low at once, even with a request still presented.
   assign stall    = reset && (!idle || (req && !hit));
   assign readData = (reset && idle && memRead && hit) ? data_q[idx][wsel] : 32'd0;

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      start_miss = 1'b0;
      wb_done    = 1'b0;
      rf_wr      = 1'b0;
      rf_done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               start_miss = 1'b1;
               beat_d     = 2'd0;
               req_d      = 1'b1;
               if (valid_q[idx] && dirty_q[idx]) begin
                  state_d = WRITEBACK;
                  we_d    = 1'b1;
                  addr_d  = {tag_q[idx], idx, 4'b0000};
                  wdata_d = data_q[idx][0];
               end else begin
                  state_d = REFILL;
                  we_d    = 1'b0;
                  addr_d  = {tag, idx, 4'b0000};
                  wdata_d = 32'd0;
               end
            end
         end
         WRITEBACK: begin
            if (mem.mem_ready) begin
               if (beat_q == 2'd3) begin
                  wb_done = 1'b1;
                  state_d = REFILL;
                  beat_d  = 2'd0;
                  we_d    = 1'b0;
                  addr_d  = {m_tag, m_idx, 4'b0000};
                  wdata_d = 32'd0;
               end else begin
                  beat_d  = beat_n;
                  addr_d  = {tag_q[m_idx], m_idx, beat_n, 2'b00};
                  wdata_d = data_q[m_idx][beat_n];
               end
            end
         end
         REFILL: begin
            if (mem.mem_ready) begin
               rf_wr = 1'b1;
               if (beat_q == 2'd3) begin
                  rf_done = 1'b1;
                  state_d = IDLE;
                  beat_d  = 2'd0;
                  req_d   = 1'b0;
                  we_d    = 1'b0;
               end else begin
                  beat_d = beat_n;
                  addr_d = {m_tag, m_idx, beat_n, 2'b00};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         beat_q      <= 2'd0;
         miss_addr_q <= 32'd0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         if (start_miss) miss_addr_q <= address;
      end
   end

   // Line state; dirty data is simply dropped on reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (hit_store) dirty_q[idx] <= 1'b1;
         if (wb_done)   dirty_q[m_idx] <= 1'b0;
         if (rf_done) begin
            valid_q[m_idx] <= 1'b1;
            dirty_q[m_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (hit_store)          data_q[idx][wsel]     <= writeData;
      if (reset && rf_wr)     data_q[m_idx][beat_q] <= mem.mem_rdata;
      if (reset && rf_done)   tag_q[m_idx]          <= m_tag;
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         if (idle && req && hit) hit_count  <= hit_count + 32'd1;
         if (start_miss)         miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_data_cache.sv
// Directed and random checks of data_cache against a flat-memory reference view
// plus a line-residency model that predicts stall lengths.
module tb_data_cache;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address = 32'd0, writeData = 32'd0, readData;
   logic        memRead = 1'b0, memWrite = 1'b0, stall;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   data_cache_if mif();

   data_cache #(.INDEX_BITS(4)) dut (
      .clk(clk), .reset(reset), .address(address), .writeData(writeData),
      .memWrite(memWrite), .memRead(memRead), .readData(readData), .mem(mif),
`ifdef DCACHE_STATS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .stall(stall));

   always #5 clk = ~clk;

   // Backing memory covers byte addresses 0..0xFFF.
   logic [31:0] bmem     [1024];
   logic [31:0] ref_view [1024];
   logic        rdy = 1'b0;
   int          wait_n = 0;
   int          wcnt = 0;
   logic [32:0] mq[$];
   int          total = 0, bad = 0;

   bit          mval   [16];
   bit          mdirty [16];
   int          mtag   [16];
   int          hits = 0, misses = 0;

   assign mif.mem_rdata = bmem[mif.mem_addr[11:2]];
   assign mif.mem_ready = rdy;

   // Ready goes high after wait_n low cycles per beat.
   always @(negedge clk) begin
      if (mif.mem_req) begin
         if (wcnt >= wait_n) begin rdy = 1'b1; wcnt = 0; end
         else begin rdy = 1'b0; wcnt = wcnt + 1; end
      end else begin
         rdy = 1'b0; wcnt = 0;
      end
   end

   always @(posedge clk) begin
      if (reset && mif.mem_req && mif.mem_ready) begin
         mq.push_back({mif.mem_we, mif.mem_addr});
         if (mif.mem_we) bmem[mif.mem_addr[11:2]] = mif.mem_wdata;
      end
   end

   task automatic check(input string tg, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
      end
   endtask

   task automatic check_beats(input string tg, input bit we, input logic [31:0] base);
      logic [32:0] e;
      for (int k = 0; k < 4; k++) begin
         e = (mq.size() > 0) ? mq.pop_front() : 33'h1_FFFF_FFFF;
         check(tg, {7'd0, e}, {7'd0, we, base + 32'(4 * k)});
      end
   endtask

   task automatic access(input logic [31:0] a, input logic [31:0] wd, input bit rd,
                         input bit wr, input int wn, input string tg);
      int idx, t, wi, exp_stall, n, viol;
      bit res, pv, pr;
      logic [31:0] exp_rd, pa;
      idx = int'(a[7:4]); t = int'(a[11:8]); wi = int'(a[11:2]);
      res = mval[idx] && (mtag[idx] == t);
      if (res) exp_stall = 0;
      else if (mval[idx] && mdirty[idx]) exp_stall = 1 + 8 * (wn + 1);
      else exp_stall = 1 + 4 * (wn + 1);
      exp_rd = rd ? ref_view[wi] : 32'd0;
      wait_n = wn;
      @(negedge clk);
      address = a; writeData = wd; memRead = rd; memWrite = wr;
      n = 0; viol = 0; pv = 1'b0; pr = 1'b0; pa = 32'd0;
      #1;
      while (stall && n < 200) begin
         n++;
         if (n > 1 && !mif.mem_req) viol++;
         if (pv && !pr && mif.mem_addr !== pa) viol++;
         pv = mif.mem_req; pa = mif.mem_addr; pr = mif.mem_ready;
         @(negedge clk); #1;
      end
      check({tg, "_stall"}, 40'(n), 40'(exp_stall));
      check({tg, "_rdata"}, {8'd0, readData}, {8'd0, exp_rd});
      check({tg, "_hold"}, 40'(viol), 40'd0);
      if (!res) begin
         mval[idx] = 1'b1; mtag[idx] = t; mdirty[idx] = 1'b0; misses++;
      end
      hits++;
      if (wr) begin ref_view[wi] = wd; mdirty[idx] = 1'b1; end
   endtask

   task automatic go_idle();
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin mval[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = 0; end
      for (int i = 0; i < 1024; i++) ref_view[i] = bmem[i];
      hits = 0; misses = 0;
   endtask

   initial begin
      logic [31:0] a;
      int op;
      for (int i = 0; i < 1024; i++) bmem[i] = $urandom;
      bmem[32'h40] = 32'hAAAA0001;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_stall", {39'd0, stall}, 40'd0);
      check("rst_req",   {39'd0, mif.mem_req}, 40'd0);
      check("rst_addr",  {8'd0, mif.mem_addr}, 40'd0);
      check("rst_rdata", {8'd0, readData}, 40'd0);

      mq.delete();
      access(32'h100, 32'd0, 1'b1, 1'b0, 0, "clean_miss");
      check_beats("refill_100", 1'b0, 32'h100);
      access(32'h104, 32'd0, 1'b1, 1'b0, 0, "hit_104");
      mq.delete();
      access(32'h108, 32'hDEADBEEF, 1'b0, 1'b1, 0, "store_hit");
      check("store_no_req", 40'(mq.size()), 40'd0);
      access(32'h508, 32'd0, 1'b1, 1'b0, 0, "dirty_miss");
      check_beats("wb_100", 1'b1, 32'h100);
      check_beats("refill_500", 1'b0, 32'h500);
      check("wb_data", {8'd0, bmem[32'h42]}, {8'd0, 32'hDEADBEEF});

      mq.delete();
      access(32'h208, 32'd0, 1'b1, 1'b0, 2, "wait_miss");
      check_beats("refill_200", 1'b0, 32'h200);
      access(32'h204, 32'h12345678, 1'b1, 1'b1, 0, "rw_hit");
      access(32'h204, 32'd0, 1'b1, 1'b0, 0, "rw_after");
      go_idle();

      // Reset during refill beat 2 of a clean miss to 0x3C0.
      wait_n = 0;
      @(negedge clk);
      address = 32'h3C0; memRead = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
      check("midrst_req",   {39'd0, mif.mem_req}, 40'd0);
      check("midrst_stall", {39'd0, stall}, 40'd0);
      check("midrst_addr",  {8'd0, mif.mem_addr}, 40'd0);
      reset = 1'b1; memRead = 1'b0;
      model_reset();
      mq.delete();
      access(32'h3C0, 32'd0, 1'b1, 1'b0, 0, "remiss");
      access(32'h3C4, 32'd0, 1'b1, 1'b0, 0, "hit_a");
      access(32'h3C8, 32'd0, 1'b1, 1'b0, 0, "hit_b");
      access(32'h3C0, 32'd0, 1'b1, 1'b0, 0, "hit_c");
`ifdef DCACHE_STATS_EN
      #1;
      check("stat_hit",  {8'd0, hit_count},  40'(hits));
      check("stat_miss", {8'd0, miss_count}, 40'(misses));
`endif

      for (int k = 0; k < 300; k++) begin
         a = {20'd0, 2'b00, 2'($urandom_range(0, 3)), 2'b00,
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         op = $urandom_range(0, 2);
         access(a, $urandom, op != 1, op != 0, $urandom_range(0, 1), "rnd");
      end
      go_idle();
      @(negedge clk); #1;
`ifdef DCACHE_STATS_EN
      check("rnd_stat_hit",  {8'd0, hit_count},  40'(hits));
      check("rnd_stat_miss", {8'd0, miss_count}, 40'(misses));
`endif
      check("end_idle", {39'd0, stall}, 40'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
